// File: rtl/buffer_ctrl.sv
// buffer_ctrl: sequences writes/reads into an external single-port buffer with round-robin arbitration.
// Optional build macro BUFCTRL_STALL_CNT_EN adds a saturating write-stall counter (stall_cnt).
module buffer_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             mem_en_w,
  output logic             mem_en_r,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
`ifdef BUFCTRL_STALL_CNT_EN
  ,
  output logic [7:0]       stall_cnt
`endif
);

  // state     | meaning
  // S_IDLE    | arbitrate write/read handshakes
  // S_WR      | write strobe at wptr with captured data
  // S_RD      | read strobe at rptr
  // S_RD_WAIT | capture mem_data_out; rd_valid pulses next cycle
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] wdata_q;
  logic [AW:0]      count_nxt;
  logic             last_rd;
  logic             idle, wr_elig, rd_elig, wr_win, rd_win, wr_hs, rd_hs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      S_IDLE: begin
        if (wr_hs)      state_nxt = S_WR;
        else if (rd_hs) state_nxt = S_RD;
      end
      S_WR: begin
        state_nxt = S_IDLE;
        count_nxt = count + (AW+1)'(1);
      end
      S_RD:      state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        state_nxt = S_IDLE;
        count_nxt = count - (AW+1)'(1);
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // On a tie the side that did not win the previous grant goes first.
  always_comb begin
    idle        = (state == S_IDLE);
    wr_elig     = idle & wr_valid & ~full;
    rd_elig     = idle & rd_req & ~empty;
    wr_win      = wr_elig & (~rd_elig | last_rd);
    rd_win      = rd_elig & (~wr_elig | ~last_rd);
    wr_ready    = idle & ~full & ~rd_win;
    rd_ready    = idle & ~empty & ~wr_win;
    wr_hs       = wr_valid & wr_ready;
    rd_hs       = rd_req & rd_ready;
    mem_en_w    = (state == S_WR);
    mem_en_r    = (state == S_RD);
    mem_addr    = '0;
    mem_data_in = '0;
    if (state == S_WR) begin
      mem_addr    = wptr;
      mem_data_in = wdata_q;
    end else if (state == S_RD) begin
      mem_addr    = rptr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wdata_q  <= '0;
      last_rd  <= 1'b1;
    end else begin
      count    <= count_nxt;
      full     <= (count_nxt == (AW+1)'(DEPTH));
      empty    <= (count_nxt == '0);
      rd_valid <= (state == S_RD_WAIT);
      if (wr_hs) begin
        wdata_q <= wr_data;
        last_rd <= 1'b0;
      end else if (rd_hs) begin
        last_rd <= 1'b1;
      end
      if (state == S_WR) wptr <= wptr + AW'(1);
      if (state == S_RD_WAIT) begin
        rptr    <= rptr + AW'(1);
        rd_data <= mem_data_out;
      end
    end
  end

`ifdef BUFCTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (wr_valid && !wr_ready && stall_cnt != 8'hFF)
      stall_cnt <= stall_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_buffer_ctrl.sv
// tb_buffer_ctrl: directed stimulus with scoreboard queues; a negedge monitor checks
// buffer strobes and read returns (data and latency) against the expected entries.
module tb_buffer_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_valid, rd_req;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready, rd_ready, rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             mem_en_w, mem_en_r;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data_in;
  logic [WIDTH-1:0] mem_data_out = '0;
  logic             full, empty;
  logic [AW:0]      count;
`ifdef BUFCTRL_STALL_CNT_EN
  logic [7:0]       stall_cnt;
`endif

  buffer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en_w(mem_en_w), .mem_en_r(mem_en_r), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .full(full), .empty(empty), .count(count)
`ifdef BUFCTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Downstream buffer: read data appears the cycle after mem_en_r.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en_w) mem[mem_addr] <= mem_data_in;
    if (mem_en_r) mem_data_out <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int c; } rd_exp_t;
  rd_exp_t        rq[$];
  logic [10:0]    wq[$];
  logic [2:0]     raq[$];
  logic [7:0]     fifo_m[$];
  int             count_m = 0;
  logic [2:0]     wptr_m = '0, rptr_m = '0;
  int             checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  initial begin : monitor
    rd_exp_t     e;
    logic [10:0] w;
    logic [2:0]  a;
    forever begin
      @(negedge clk);
      if (mem_en_w || mem_en_r) chk("strobe_excl", 32'(mem_en_w & mem_en_r), 32'd0);
      if (mem_en_w) begin
        if (wq.size() == 0) fail("unexpected_mem_en_w");
        else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w[10:8]));
          chk("wr_data", 32'(mem_data_in), 32'(w[7:0]));
        end
      end
      if (mem_en_r) begin
        if (raq.size() == 0) fail("unexpected_mem_en_r");
        else begin
          a = raq.pop_front();
          chk("rd_addr", 32'(mem_addr), 32'(a));
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) fail("unexpected_rd_valid");
        else begin
          e = rq.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e.d));
          chk("rd_latency", 32'(cyc), 32'(e.c));
        end
      end
      if (rq.size() > 0 && cyc > rq[0].c) begin
        fail("rd_valid_missing");
        void'(rq.pop_front());
      end
    end
  end

  task automatic do_write(input logic [7:0] d);
    int n = 0;
    bit done = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    while (!done) begin
      #1;
      if (wr_ready) begin
        chk("wr_hs_count", 32'(count), 32'(count_m));
        wq.push_back({wptr_m, d});
        fifo_m.push_back(d);
        wptr_m++;
        count_m++;
        done = 1;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_data  = 8'hA5;
      end else if (++n > 20) begin
        fail("wr_handshake_timeout");
        wr_valid = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic do_read();
    int n = 0;
    bit done = 0;
    rd_exp_t e;
    @(negedge clk);
    rd_req = 1'b1;
    while (!done) begin
      #1;
      if (rd_ready) begin
        chk("rd_hs_count", 32'(count), 32'(count_m));
        raq.push_back(rptr_m);
        e.d = fifo_m.pop_front();
        e.c = cyc + 3;
        rq.push_back(e);
        rptr_m++;
        count_m--;
        done = 1;
        @(negedge clk);
        rd_req = 1'b0;
      end else if (++n > 20) begin
        fail("rd_handshake_timeout");
        rd_req = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic both_hold(input int n_grants);
    int grants = 0, n = 0;
    bit exp_wr = 1;
    logic [7:0] nd = 8'h40;
    rd_exp_t e;
    @(negedge clk);
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    while (grants < n_grants && n < 100) begin
      wr_data = nd;
      #1;
      if (wr_ready || rd_ready) begin
        chk("rr_wr_grant", 32'(wr_ready), 32'(exp_wr));
        chk("rr_rd_grant", 32'(rd_ready), 32'(!exp_wr));
        chk("rr_count", 32'(count), 32'(count_m));
        if (wr_ready) begin
          wq.push_back({wptr_m, nd});
          fifo_m.push_back(nd);
          wptr_m++;
          count_m++;
          nd++;
        end else begin
          raq.push_back(rptr_m);
          e.d = fifo_m.pop_front();
          e.c = cyc + 3;
          rq.push_back(e);
          rptr_m++;
          count_m--;
        end
        exp_wr = !exp_wr;
        grants++;
      end
      @(negedge clk);
      n++;
    end
    if (grants < n_grants) fail("rr_grant_timeout");
    wr_valid = 1'b0;
    rd_req   = 1'b0;
  endtask

  initial begin : stim
    int n;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    wr_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_mem_en", 32'({mem_en_w, mem_en_r}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    reset_n = 1'b1;

    // Fill: addresses 0..7 checked by monitor
    for (int i = 0; i < 8; i++) do_write(8'h11 + 8'(i));
    @(negedge clk);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("full_count_hold", 32'(count), 32'd8);

    // Drain in order
    for (int i = 0; i < 8; i++) do_read();
    repeat (2) @(negedge clk);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("empty_rd_ready", 32'(rd_ready), 32'd0);
      @(negedge clk);
    end
    rd_req = 1'b0;

    // Interleaved traffic, both pointers wrap 7->0
    for (int i = 0; i < 3; i++) do_write(8'h21 + 8'(i));
    for (int i = 0; i < 7; i++) begin
      do_write(8'h24 + 8'(i));
      chk("wrap_count_le8", 32'(count_m <= 8), 32'(count <= 4'd8));
      do_read();
    end
    for (int i = 0; i < 3; i++) do_read();
    repeat (2) @(negedge clk);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Contention at count=4 with last grant = read
    for (int i = 0; i < 5; i++) do_write(8'h31 + 8'(i));
    do_read();
    repeat (2) @(negedge clk);
    both_hold(8);
    for (int i = 0; i < 4; i++) do_read();
    repeat (2) @(negedge clk);
    chk("rr_drain_empty", 32'(empty), 32'd1);

    // Reset during RD aborts the read
    do_write(8'h55);
    @(negedge clk);
    rd_req = 1'b1;
    #1;
    chk("abort_rd_ready", 32'(rd_ready), 32'd1);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    chk("abort_in_rd", 32'(mem_en_r), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_en_r", 32'(mem_en_r), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    fifo_m.delete();
    count_m = 0;
    wptr_m  = '0;
    rptr_m  = '0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    do_write(8'h66);
    do_read();
    repeat (2) @(negedge clk);

`ifdef BUFCTRL_STALL_CNT_EN
    for (int i = 0; i < 8; i++) do_write(8'h70 + 8'(i));
    @(negedge clk);
    wr_valid = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd255);
    wr_valid = 1'b0;
`endif

    n = 0;
    while ((rq.size() || wq.size() || raq.size()) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() || wq.size() || raq.size()) fail("scoreboard_not_drained");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
